// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared load/store constants, FSM encoding and access sizing
// for the MEM-stage data-memory access unit.
package riscv_mem_pkg;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 16;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  // Unlisted funct3 codes fall back to a word access.
  function automatic mem_size_e size_of(
    input logic       is_load,
    input logic [2:0] f3
  );
    mem_size_e sz;
    sz = SZ_W;
    if (f3 == F3_LB || (is_load && f3 == F3_LBU))
      sz = SZ_B;
    else if (f3 == F3_LH || (is_load && f3 == F3_LHU))
      sz = SZ_H;
    return sz;
  endfunction

  function automatic logic misaligned(
    input mem_size_e  sz,
    input logic [1:0] lo
  );
    return (sz == SZ_H && lo[0]) ||
           (sz == SZ_W && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_unit_load_formatter.sv
// load_formatter: selects the byte/halfword lane of a read word and
// sign- or zero-extends it to 32 bits.
module load_formatter
  import riscv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Lane selection by the low address bits.
  always_comb begin
    byte_v = rdata[7:0];
    unique case (addr)
      2'd0: byte_v = rdata[7:0];
      2'd1: byte_v = rdata[15:8];
      2'd2: byte_v = rdata[23:16];
      2'd3: byte_v = rdata[31:24];
      default: byte_v = rdata[7:0];
    endcase
    half_v = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extension by load type; other codes return the whole word.
  always_comb begin
    result = rdata;
    unique case (funct3)
      F3_LB:   result = {{24{byte_v[7]}}, byte_v};
      F3_LH:   result = {{16{half_v[15]}}, half_v};
      F3_LBU:  result = {24'h0, byte_v};
      F3_LHU:  result = {16'h0, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with bus timeout.
// Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_load_en,
  input  logic        mem_store_en,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_calculated_result,
  input  logic [31:0] mem_store_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_read_data,
  output logic        mem_stall,
  output logic        mem_bus_err,
  output logic        mem_misaligned
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  mau_state_e  state_q;
  mau_state_e  state_d;
  logic [7:0]  cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic [1:0]  lo;
  logic        req_any;
  logic        is_load;
  logic        accept;
  logic        timeout;
  logic        trap;
  mem_size_e   sz;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] fmt_data;

  assign lo      = mem_calculated_result[1:0];
  assign req_any = mem_load_en | mem_store_en;
  assign is_load = mem_load_en;
  assign sz      = size_of(is_load, mem_funct3);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = (state_q == S_IDLE) && req_any &&
                misaligned(sz, lo);
`else
  assign trap = 1'b0;
`endif

  load_formatter u_fmt (
    .rdata  (dmem_rdata),
    .addr   (lo_q),
    .funct3 (f3_q),
    .result (fmt_data)
  );

  // Store lane replication and strobes; reads carry no strobes.
  always_comb begin
    wdata_d = mem_store_data;
    wstrb_d = 4'b1111;
    unique case (sz)
      SZ_B: begin
        wdata_d = {4{mem_store_data[7:0]}};
        wstrb_d = 4'b0001 << lo;
      end
      SZ_H: begin
        wdata_d = {2{mem_store_data[15:0]}};
        wstrb_d = lo[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata_d = mem_store_data;
        wstrb_d = 4'b1111;
      end
    endcase
    if (is_load)
      wstrb_d = 4'b0000;
  end

  // Next-state, acceptance, timeout and stall.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    timeout   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_any && !trap) begin
          accept  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (dmem_ack) begin
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    mem_stall = accept || (state_q == S_BUSY);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Request registers, busy counter and formatted load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      dmem_wstrb    <= '0;
      mem_read_data <= '0;
      mem_bus_err   <= 1'b0;
      cnt_q         <= '0;
      f3_q          <= '0;
      lo_q          <= '0;
    end else begin
      mem_bus_err <= timeout;
      if (accept) begin
        dmem_req   <= 1'b1;
        dmem_we    <= ~is_load;
        dmem_addr  <= {mem_calculated_result[31:2], 2'b00};
        dmem_wdata <= wdata_d;
        dmem_wstrb <= wstrb_d;
        f3_q       <= mem_funct3;
        lo_q       <= lo;
        cnt_q      <= '0;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q + 8'd1;
        if (dmem_ack || timeout) begin
          dmem_req      <= 1'b0;
          mem_read_data <= (dmem_ack && !dmem_we) ?
                           fmt_data : '0;
        end
      end
      if (trap)
        mem_read_data <= '0;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle registered trap pulse.
  always_ff @(posedge clk) begin
    if (rst)
      mem_misaligned <= 1'b0;
    else
      mem_misaligned <= trap;
  end
`else
  assign mem_misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store accesses checked
// against a behavioural model of the data-memory access rules.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic        mem_load_en;
  logic        mem_store_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_calculated_result;
  logic [31:0] mem_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] mem_read_data;
  logic        mem_stall;
  logic        mem_bus_err;
  logic        mem_misaligned;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .mem_load_en           (mem_load_en),
    .mem_store_en          (mem_store_en),
    .mem_funct3            (mem_funct3),
    .mem_calculated_result (mem_calculated_result),
    .mem_store_data        (mem_store_data),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_wstrb            (dmem_wstrb),
    .dmem_ack              (dmem_ack),
    .dmem_rdata            (dmem_rdata),
    .mem_read_data         (mem_read_data),
    .mem_stall             (mem_stall),
    .mem_bus_err           (mem_bus_err),
    .mem_misaligned        (mem_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from the funct3 rules.
  function automatic int size_m(input logic ld, input logic [2:0] f3);
    if (f3 == 3'd0 || (ld && f3 == 3'd4)) return 1;
    if (f3 == 3'd1 || (ld && f3 == 3'd5)) return 2;
    return 4;
  endfunction

  function automatic int off_m(input int sz, input logic [31:0] a);
    int lo;
    lo = int'(a % 32'd4);
    if (sz == 1) return lo;
    if (sz == 2) return (lo / 2) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] load_m(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] rd);
    int sz;
    int off;
    logic [31:0] mask;
    logic [31:0] v;
    sz = size_m(1'b1, f3);
    off = off_m(sz, a);
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v = (rd >> (8 * off)) & mask;
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8 * sz - 1])
      v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] strb_m(input int sz, input logic [31:0] a);
    int s;
    s = ((1 << sz) - 1) << off_m(sz, a);
    return s[3:0];
  endfunction

  function automatic logic [31:0] wdata_m(input int sz, input logic [31:0] sd);
    if (sz == 1) return 32'(sd[7:0]) * 32'h0101_0101;
    if (sz == 2) return 32'(sd[15:0]) * 32'h0001_0001;
    return sd;
  endfunction

  task automatic zero_check(input string tag);
    check({tag, "_req"}, dmem_req, 0);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_wstrb"}, dmem_wstrb, 0);
    check({tag, "_rd"}, mem_read_data, 0);
    check({tag, "_err"}, mem_bus_err, 0);
    check({tag, "_mis"}, mem_misaligned, 0);
    check({tag, "_stall"}, mem_stall, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_load_en = 1'b0;
      mem_store_en = 1'b0;
      dmem_ack = 1'b0;
      #1;
      check("idle_req", dmem_req, 0);
      check("idle_stall", mem_stall, 0);
      check("idle_rd", mem_read_data, exp_rd);
    end
  endtask

  task automatic garbage();
    mem_load_en = 1'($urandom);
    mem_store_en = 1'($urandom);
    mem_funct3 = 3'($urandom);
    mem_calculated_result = $urandom;
    mem_store_data = $urandom;
  endtask

  // One complete access; ack_at is the BUSY cycle index of the ack,
  // values >= TO withhold it.
  task automatic access(input logic ld, input logic st,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rd,
                        input int ack_at);
    int sz;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic [3:0] e_strb;
    logic e_mis;
    logic done;
    sz = size_m(ld, f3);
    e_addr = a & 32'hFFFF_FFFC;
    e_strb = ld ? 4'b0000 : strb_m(sz, a);
    e_wd = wdata_m(sz, sd);
    e_mis = (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
    @(negedge clk);
    check("pre_req", dmem_req, 0);
    check("pre_err", mem_bus_err, 0);
    mem_load_en = ld;
    mem_store_en = st;
    mem_funct3 = f3;
    mem_calculated_result = a;
    mem_store_data = sd;
    dmem_ack = 1'b0;
    #1;
`ifdef MEM_MISALIGN_TRAP_EN
    if (e_mis) begin
      check("trap_stall", mem_stall, 0);
      @(posedge clk);
      #1;
      check("trap_req", dmem_req, 0);
      check("trap_pulse", mem_misaligned, 1);
      check("trap_rd", mem_read_data, 0);
      exp_rd = '0;
      @(negedge clk);
      mem_load_en = 1'b0;
      mem_store_en = 1'b0;
      return;
    end
`else
    if (e_mis) check("align_stall", mem_stall, 1);
`endif
    check("acc_stall", mem_stall, 1);
    @(posedge clk);
    #1;
    check("req", dmem_req, 1);
    check("we", dmem_we, !ld);
    check("addr", dmem_addr, e_addr);
    check("wstrb", dmem_wstrb, e_strb);
    if (!ld) check("wdata", dmem_wdata, e_wd);
    done = 1'b0;
    for (int k = 0; k < TO && !done; k++) begin
      @(negedge clk);
      garbage();
      dmem_ack = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rd : $urandom;
      #1;
      check("busy_stall", mem_stall, 1);
      check("busy_req", dmem_req, 1);
      check("busy_addr", dmem_addr, e_addr);
      check("busy_wstrb", dmem_wstrb, e_strb);
      if (!ld) check("busy_wdata", dmem_wdata, e_wd);
      @(posedge clk);
      #1;
      done = (k == ack_at);
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    garbage();
    #1;
    e_rd = (ld && ack_at < TO) ? load_m(f3, a, rd) : 32'h0;
    check("done_stall", mem_stall, 0);
    check("done_req", dmem_req, 0);
    check("done_rd", mem_read_data, e_rd);
    check("done_err", mem_bus_err, ack_at >= TO);
    check("done_mis", mem_misaligned, 0);
    exp_rd = e_rd;
  endtask

  initial begin
    rst = 1'b1;
    mem_load_en = 1'b0;
    mem_store_en = 1'b0;
    mem_funct3 = '0;
    mem_calculated_result = '0;
    mem_store_data = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    zero_check("reset");
    @(negedge clk);
    rst = 1'b0;

    access(1, 0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 0);
    access(1, 0, 3'd2, 32'h000, 32'h0, 32'h1111_1111, 8);
    access(1, 0, 3'd2, 32'h010, 32'h0, 32'hA5A5_A5A5, TO - 1);
    access(0, 1, 3'd1, 32'h202, 32'h0000_BEEF, 32'h0, 1);
    access(1, 0, 3'd2, 32'h101, 32'h77, 32'hCAFE_F00D, 0);
    access(1, 0, 3'd5, 32'h002, 32'h0, 32'h8001_7FFE, 0);
    access(0, 1, 3'd0, 32'h001, 32'h5A, 32'h0, 0);
    access(1, 1, 3'd4, 32'h2F1, 32'h0, 32'h00C3_0000, 2);
    access(1, 0, 3'd2, 32'h044, 32'hFFFF_0000, 32'h1234_5678, 1);

    @(negedge clk);
    mem_load_en = 1'b1;
    mem_store_en = 1'b0;
    mem_funct3 = 3'd2;
    mem_calculated_result = 32'h48;
    mem_store_data = 32'hDEAD_0001;
    @(posedge clk);
    #1;
    check("rb_req", dmem_req, 1);
    @(negedge clk);
    mem_load_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    zero_check("midrst");
    exp_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    access(1, 0, 3'd1, 32'h086, 32'h0, 32'h9ABC_0000, 1);

    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      access(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom,
             $urandom, $urandom_range(0, TO + 1));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
